// File: rtl/dut_mem_ram_if.sv
// Port bundle for the single-port RAM: enable, write enable, address, write data and read data.
// The tester engine is the master; the RAM is the slave.
interface dut_mem_ram_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;

    modport master (output ena, wea, addra, dina, input douta);
    modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/dut_mem_ram.sv
// Single-port synchronous RAM standing in for the loadboard memory chip.
// Selectable read latency (1 or 2) and output behaviour during writes.
module dut_mem_ram #(
    parameter int                    ADDR_WIDTH   = 15,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter string                 WRITE_MODE   = "WRITE_FIRST",
    parameter logic [DATA_WIDTH-1:0] RST_VALUE    = '0
) (
    input logic          clka,
    input logic          rsta,
    dut_mem_ram_if.slave bus
);
    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
    localparam bit READ_FIRST  = (WRITE_MODE == "READ_FIRST");

    // The array powers up cleared; reset never touches it.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] dout_p0     = RST_VALUE;

    always_ff @(posedge clka) begin
        if (bus.ena && bus.wea) begin
            mem[bus.addra] <= bus.dina;
        end
    end

    // Stage 0: array read port, write-mode selection, reset priority
    always_ff @(posedge clka) begin
        if (rsta) begin
            dout_p0 <= RST_VALUE;
        end else if (bus.ena) begin
            if (!bus.wea) begin
                dout_p0 <= mem[bus.addra];
            end else if (WRITE_FIRST) begin
                dout_p0 <= bus.dina;
            end else if (READ_FIRST) begin
                dout_p0 <= mem[bus.addra];
            end
        end
    end

    // Stage 1: optional extra output register, advancing only on enabled cycles
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] dout_p1 = RST_VALUE;

            always_ff @(posedge clka) begin
                if (rsta) begin
                    dout_p1 <= RST_VALUE;
                end else if (bus.ena) begin
                    dout_p1 <= dout_p0;
                end
            end

            assign bus.douta = dout_p1;
        end else begin : g_lat1
            assign bus.douta = dout_p0;
        end
    endgenerate
endmodule

// File: tb/tb_dut_mem_ram.sv
// Bench for dut_mem_ram: four instances (WRITE_FIRST, READ_FIRST, NO_CHANGE, latency 2)
// share one stimulus stream and are checked against an array-based reference model.
module tb_dut_mem_ram;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dut_mem_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_wf ();
    dut_mem_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rf ();
    dut_mem_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_nc ();
    dut_mem_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_l2 ();

    assign bus_rf.ena = bus_wf.ena;  assign bus_rf.wea = bus_wf.wea;
    assign bus_rf.addra = bus_wf.addra;  assign bus_rf.dina = bus_wf.dina;
    assign bus_nc.ena = bus_wf.ena;  assign bus_nc.wea = bus_wf.wea;
    assign bus_nc.addra = bus_wf.addra;  assign bus_nc.dina = bus_wf.dina;
    assign bus_l2.ena = bus_wf.ena;  assign bus_l2.wea = bus_wf.wea;
    assign bus_l2.addra = bus_wf.addra;  assign bus_l2.dina = bus_wf.dina;

    dut_mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .WRITE_MODE("WRITE_FIRST"))
        u_wf (.clka(clk), .rsta(rst), .bus(bus_wf));
    dut_mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .WRITE_MODE("READ_FIRST"))
        u_rf (.clka(clk), .rsta(rst), .bus(bus_rf));
    dut_mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .WRITE_MODE("NO_CHANGE"))
        u_nc (.clka(clk), .rsta(rst), .bus(bus_nc));
    dut_mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .WRITE_MODE("WRITE_FIRST"))
        u_l2 (.clka(clk), .rsta(rst), .bus(bus_l2));

    int checks   = 0;
    int failures = 0;

    // Reference model: the memory contents plus the value each output should show.
    logic [DW-1:0] mem_m [1 << AW];
    logic [DW-1:0] e_wf = '0, e_rf = '0, e_nc = '0;
    logic [DW-1:0] e_l2_first = '0, e_l2 = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wf"}, bus_wf.douta, e_wf);
        chk({tag, "_rf"}, bus_rf.douta, e_rf);
        chk({tag, "_nc"}, bus_nc.douta, e_nc);
        chk({tag, "_l2"}, bus_l2.douta, e_l2);
    endtask

    // One clock cycle: drive on the falling edge, advance the model at the rising edge, check after it.
    task automatic step(input string tag, input logic en, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] din, input logic r);
        logic [DW-1:0] old;
        @(negedge clk);
        bus_wf.ena = en;  bus_wf.wea = we;  bus_wf.addra = addr;  bus_wf.dina = din;  rst = r;
        @(posedge clk);
        old = mem_m[addr];
        if (en && we) mem_m[addr] = din;
        if (r) begin
            e_wf = '0;  e_rf = '0;  e_nc = '0;  e_l2_first = '0;  e_l2 = '0;
        end else if (en) begin
            e_l2 = e_l2_first;
            if (!we) begin
                e_wf = old;  e_rf = old;  e_nc = old;  e_l2_first = old;
            end else begin
                e_wf = din;  e_rf = old;  e_l2_first = din;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a);
        step(tag, 1'b1, 1'b0, a, '0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(tag, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        bus_wf.ena = 1'b0;  bus_wf.wea = 1'b0;  bus_wf.addra = '0;  bus_wf.dina = '0;
        #1;
        check_all("powerup");

        step("reset", 1'b0, 1'b0, '0, '0, 1'b1);
        idle("post_reset");

        // Single writes with idle gaps, then back-to-back reads
        wr("t1_w1", 15'd1, 8'd1);  idle("t1_gap");
        wr("t1_w2", 15'd2, 8'd2);  idle("t1_gap");
        wr("t1_w3", 15'd3, 8'd3);  idle("t1_gap");
        rd("t1_r1", 15'd1);  chk("t1_const1", bus_wf.douta, 8'd1);
        rd("t1_r2", 15'd2);  chk("t1_const2", bus_wf.douta, 8'd2);
        chk("t1_l2_const1", bus_l2.douta, 8'd1);
        rd("t1_r3", 15'd3);  chk("t1_const3", bus_wf.douta, 8'd3);
        rd("t1_r4", 15'd4);  chk("t1_const4", bus_wf.douta, 8'd0);
        chk("t1_l2_const3", bus_l2.douta, 8'd3);
        rd("t1_flush", 15'd1);
        chk("t1_l2_const4", bus_l2.douta, 8'd0);
        idle("t1_end");

        // Burst write then burst read
        for (int i = 0; i < 11; i++) wr("t2_w", AW'(4 + i), DW'(i));
        for (int i = 0; i < 11; i++) begin
            rd("t2_r", AW'(i));
            chk("t2_const", bus_wf.douta, (i < 4) ? DW'(i) : DW'(i - 4));
        end
        rd("t2_flush", 15'd0);

        // Disabled port ignores writes and holds its output
        wr("t3_pre", 15'd9, 8'h3C);
        for (int i = 0; i < 50; i++)
            step("t3_hold", 1'b0, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
        chk("t3_hold_const", bus_wf.douta, 8'h3C);
        rd("t3_chk9", 15'd9);
        rd("t3_chk5", 15'd5);  chk("t3_const5", bus_wf.douta, 8'd1);

        // Reset in the middle of a read burst
        rd("t4_r", 15'd6);
        rd("t4_r", 15'd7);
        step("t4_rst", 1'b1, 1'b0, 15'd8, '0, 1'b1);
        chk("t4_rst_const", bus_wf.douta, 8'd0);
        rd("t4_r2", 15'd2);  chk("t4_const2", bus_wf.douta, 8'd2);
        rd("t4_flush", 15'd3);

        // Top address and address 0
        wr("t5_wtop", 15'h7FFF, 8'hA5);  chk("t5_wf_const", bus_wf.douta, 8'hA5);
        rd("t5_rtop", 15'h7FFF);  chk("t5_top_const", bus_wf.douta, 8'hA5);
        rd("t5_r0", 15'h0000);    chk("t5_zero_const", bus_wf.douta, 8'h00);
        wr("t5_wb", 15'd12, 8'h77);
        rd("t5_rb", 15'd12);      chk("t5_wr_then_rd", bus_wf.douta, 8'h77);

        // Randomized traffic over a small address window plus the top word
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 15'h7FFF : AW'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a,
                 DW'($urandom), ($urandom_range(0, 30) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
